// File: rtl/lsu_router_pkg.sv
// Shared constants and types for the LSU region router: default region windows,
// region index type and fault counter width.
package lsu_router_pkg;

    localparam int FAULT_CNT_W   = 8;
    localparam int N_REGION_DFLT = 4;

    localparam logic [15:0] DMEM_BASE = 16'h2000;
    localparam logic [15:0] DMEM_MASK = 16'hE000;
    localparam logic [15:0] OUTP_BASE = 16'h7000;
    localparam logic [15:0] OUTP_MASK = 16'hFFC0;
    localparam logic [15:0] INP_BASE  = 16'h7800;
    localparam logic [15:0] INP_MASK  = 16'hFFC0;
    // Small window inside DMEM; it only ever wins when DMEM is moved away.
    localparam logic [15:0] DBUF_BASE = 16'h2000;
    localparam logic [15:0] DBUF_MASK = 16'hFF00;

    typedef logic [$clog2(N_REGION_DFLT)-1:0] rgn_idx_t;

endpackage

// File: rtl/lsu_region_router_if.sv
// LSU-side request bus, region-side select/data bus, load return and fault record.
// The router is the slave; the LSU plus region banks together form the master.
interface lsu_region_router_if
    import lsu_router_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int N_REGION = 4
);
    // No backpressure: a request is taken in every cycle i_lsu_vld is high and
    // every region must accept the access presented on o_rgn_* that same cycle.
    logic                     i_lsu_vld;
    logic                     i_lsu_we;
    logic [ADDR_W-1:0]        i_lsu_addr;
    logic [DATA_W-1:0]        i_lsu_wdata;
    logic [DATA_W/8-1:0]      i_lsu_bmask;
    logic [N_REGION-1:0]      o_rgn_sel;
    logic                     o_rgn_we;
    logic [ADDR_W-1:0]        o_rgn_addr;
    logic [DATA_W-1:0]        o_rgn_wdata;
    logic [DATA_W/8-1:0]      o_rgn_bmask;
    logic [N_REGION*DATA_W-1:0] i_rgn_rdata;
    logic                     o_ld_vld;
    logic [DATA_W-1:0]        o_ld_data;
    logic                     o_fault;
    logic [ADDR_W-1:0]        o_fault_addr;
    logic [FAULT_CNT_W-1:0]   o_fault_cnt;
    logic                     i_fault_clr;

    modport slave (
        input  i_lsu_vld, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
        input  i_rgn_rdata, i_fault_clr,
        output o_rgn_sel, o_rgn_we, o_rgn_addr, o_rgn_wdata, o_rgn_bmask,
        output o_ld_vld, o_ld_data, o_fault, o_fault_addr, o_fault_cnt
    );

    modport master (
        output i_lsu_vld, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
        output i_rgn_rdata, i_fault_clr,
        input  o_rgn_sel, o_rgn_we, o_rgn_addr, o_rgn_wdata, o_rgn_bmask,
        input  o_ld_vld, o_ld_data, o_fault, o_fault_addr, o_fault_cnt
    );

endinterface

// File: rtl/lsu_region_router_match.sv
// Combinational base/mask window match with lowest-index priority:
// one-hot winner, its encoded index and an any-hit flag.
module lsu_region_match #(
    parameter int ADDR_W   = 16,
    parameter int N_REGION = 4,
    parameter int IDX_W    = 2,
    parameter logic [N_REGION-1:0][ADDR_W-1:0] RGN_BASE = '0,
    parameter logic [N_REGION-1:0][ADDR_W-1:0] RGN_MASK = '0
) (
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [N_REGION-1:0] o_hit_oh,
    output logic [IDX_W-1:0]    o_hit_idx,
    output logic                o_hit_any
);

    always_comb begin
        o_hit_oh  = '0;
        o_hit_idx = '0;
        o_hit_any = 1'b0;
        // Walk downwards so the lowest matching index overwrites the rest.
        for (int k = N_REGION - 1; k >= 0; k--) begin
            if (((i_addr ^ RGN_BASE[k]) & RGN_MASK[k]) == '0) begin
                o_hit_oh    = '0;
                o_hit_oh[k] = 1'b1;
                o_hit_idx   = IDX_W'(k);
                o_hit_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_region_router.sv
// LSU address router: registered region select, tracked two-stage load return and
// sticky fault record. Define LSU_ROUTER_ALIGN_CHECK_EN to also fault misaligned accesses.
module lsu_region_router
    import lsu_router_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int N_REGION = 4,
    parameter logic [N_REGION-1:0][ADDR_W-1:0] RGN_BASE = {DBUF_BASE, INP_BASE, DMEM_BASE, OUTP_BASE},
    parameter logic [N_REGION-1:0][ADDR_W-1:0] RGN_MASK = {DBUF_MASK, INP_MASK, DMEM_MASK, OUTP_MASK}
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    lsu_region_router_if.slave  bus
);

    localparam int IDX_W = (N_REGION > 1) ? $clog2(N_REGION) : 1;
    localparam int BE_W  = DATA_W / 8;

    logic [N_REGION-1:0]    w_hit_oh;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_hit_any;
    logic                   w_misalign;
    logic                   w_fault;

    logic [N_REGION-1:0]    r_sel;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [BE_W-1:0]        r_bmask;
    logic                   r_fault;
    logic                   r_ld_p1;
    logic                   r_ld_map;
    logic [IDX_W-1:0]       r_ld_idx;
    logic                   r_ld_vld;
    logic [DATA_W-1:0]      r_ld_data;
    logic                   r_sticky;
    logic [ADDR_W-1:0]      r_fault_addr;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;

    lsu_region_match #(
        .ADDR_W   (ADDR_W),
        .N_REGION (N_REGION),
        .IDX_W    (IDX_W),
        .RGN_BASE (RGN_BASE),
        .RGN_MASK (RGN_MASK)
    ) u_match (
        .i_addr    (bus.i_lsu_addr),
        .o_hit_oh  (w_hit_oh),
        .o_hit_idx (w_hit_idx),
        .o_hit_any (w_hit_any)
    );

`ifdef LSU_ROUTER_ALIGN_CHECK_EN
    function automatic logic f_misaligned(input logic [BE_W-1:0] be, input logic [1:0] a_lo);
        logic [7:0] ones;
        logic [7:0] runs;
        logic       prev;
        ones = '0;
        runs = '0;
        prev = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) ones = ones + 8'd1;
            if (be[i] && !prev) runs = runs + 8'd1;
            prev = be[i];
        end
        // More than one run of set bits means the enables are non-contiguous.
        return (runs > 8'd1) ||
               (ones == 8'd2 && runs == 8'd1 && a_lo[0]) ||
               ((&be) && (a_lo != 2'b00));
    endfunction

    assign w_misalign = f_misaligned(bus.i_lsu_bmask, bus.i_lsu_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = bus.i_lsu_vld && (!w_hit_any || w_misalign);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bmask   <= '0;
            r_fault   <= 1'b0;
            r_ld_p1   <= 1'b0;
            r_ld_map  <= 1'b0;
            r_ld_idx  <= '0;
            r_ld_vld  <= 1'b0;
            r_ld_data <= '0;
        end else begin
            r_sel    <= (bus.i_lsu_vld && !w_fault) ? w_hit_oh : '0;
            r_we     <= bus.i_lsu_vld && bus.i_lsu_we && !w_fault;
            r_fault  <= w_fault;
            r_ld_p1  <= bus.i_lsu_vld && !bus.i_lsu_we;
            r_ld_map <= !w_fault;
            r_ld_idx <= w_hit_idx;
            if (bus.i_lsu_vld) begin
                r_addr  <= bus.i_lsu_addr;
                r_wdata <= bus.i_lsu_wdata;
                r_bmask <= bus.i_lsu_bmask;
            end
            // Region read data is valid in the cycle after select; faulted loads return zero.
            r_ld_vld <= r_ld_p1;
            if (r_ld_p1) begin
                r_ld_data <= r_ld_map ? bus.i_rgn_rdata[r_ld_idx*DATA_W +: DATA_W] : '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sticky     <= 1'b0;
            r_fault_addr <= '0;
            r_fault_cnt  <= '0;
        end else if (bus.i_fault_clr) begin
            // Clear drops the old record; a coincident fault starts the new one.
            r_sticky     <= w_fault;
            r_fault_addr <= w_fault ? bus.i_lsu_addr : '0;
            r_fault_cnt  <= w_fault ? FAULT_CNT_W'(1) : '0;
        end else if (w_fault) begin
            r_sticky <= 1'b1;
            if (!r_sticky) r_fault_addr <= bus.i_lsu_addr;
            if (r_fault_cnt != {FAULT_CNT_W{1'b1}}) r_fault_cnt <= r_fault_cnt + FAULT_CNT_W'(1);
        end
    end

    assign bus.o_rgn_sel    = r_sel;
    assign bus.o_rgn_we     = r_we;
    assign bus.o_rgn_addr   = r_addr;
    assign bus.o_rgn_wdata  = r_wdata;
    assign bus.o_rgn_bmask  = r_bmask;
    assign bus.o_ld_vld     = r_ld_vld;
    assign bus.o_ld_data    = r_ld_data;
    assign bus.o_fault      = r_fault;
    assign bus.o_fault_addr = r_fault_addr;
    assign bus.o_fault_cnt  = r_fault_cnt;

endmodule

// File: tb/tb_lsu_region_router.sv
// Directed bench for lsu_region_router: decode, load return order, fault record,
// reset with a load in flight and the alignment option.
module tb_lsu_region_router;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lsu_region_router_if #(.ADDR_W(16), .DATA_W(32), .N_REGION(4)) bus ();

    lsu_region_router dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
        bus.i_lsu_vld   = 1'b1;
        bus.i_lsu_we    = we;
        bus.i_lsu_addr  = addr;
        bus.i_lsu_wdata = wdata;
        bus.i_lsu_bmask = be;
    endtask

    task automatic idle();
        bus.i_lsu_vld = 1'b0;
        bus.i_lsu_we  = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_lsu_vld   = 1'b0;
        bus.i_lsu_we    = 1'b0;
        bus.i_lsu_addr  = '0;
        bus.i_lsu_wdata = '0;
        bus.i_lsu_bmask = '0;
        bus.i_fault_clr = 1'b0;
        bus.i_rgn_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        tick();
        chk("rst_sel", bus.o_rgn_sel, 4'b0000);
        chk("rst_we", bus.o_rgn_we, 1'b0);
        chk("rst_addr", bus.o_rgn_addr, 16'h0);
        chk("rst_wdata", bus.o_rgn_wdata, 32'h0);
        chk("rst_ldvld", bus.o_ld_vld, 1'b0);
        chk("rst_fault", bus.o_fault, 1'b0);
        chk("rst_fcnt", bus.o_fault_cnt, 8'h0);
        rst_n = 1'b1;

        // Store into DMEM; the overlapping window 3 must lose to region 1
        req(1'b1, 16'h2004, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        chk("st_sel", bus.o_rgn_sel, 4'b0010);
        chk("st_we", bus.o_rgn_we, 1'b1);
        chk("st_addr", bus.o_rgn_addr, 16'h2004);
        chk("st_wdata", bus.o_rgn_wdata, 32'hDEADBEEF);
        chk("st_bmask", bus.o_rgn_bmask, 4'hF);
        chk("st_fault", bus.o_fault, 1'b0);
        chk("st_ldvld_t1", bus.o_ld_vld, 1'b0);
        tick();
        chk("st_ldvld_t2", bus.o_ld_vld, 1'b0);
        chk("idle_sel", bus.o_rgn_sel, 4'b0000);
        chk("idle_we", bus.o_rgn_we, 1'b0);
        chk("idle_wdata_hold", bus.o_rgn_wdata, 32'hDEADBEEF);

        // Back-to-back loads
        req(1'b0, 16'h7010, 32'h0, 4'hF);
        tick();
        chk("ld0_sel", bus.o_rgn_sel, 4'b0001);
        chk("ld0_we", bus.o_rgn_we, 1'b0);
        chk("ld_none_yet", bus.o_ld_vld, 1'b0);
        req(1'b0, 16'h2000, 32'h0, 4'hF);
        tick();
        chk("ld1_sel", bus.o_rgn_sel, 4'b0010);
        chk("ld0_vld", bus.o_ld_vld, 1'b1);
        chk("ld0_data", bus.o_ld_data, 32'h11);
        req(1'b0, 16'h7020, 32'h0, 4'hF);
        tick();
        idle();
        chk("ld2_sel", bus.o_rgn_sel, 4'b0001);
        chk("ld1_vld", bus.o_ld_vld, 1'b1);
        chk("ld1_data", bus.o_ld_data, 32'h22);
        tick();
        chk("ld2_vld", bus.o_ld_vld, 1'b1);
        chk("ld2_data", bus.o_ld_data, 32'h11);
        tick();
        chk("ld_done", bus.o_ld_vld, 1'b0);

        // Unmapped load
        req(1'b0, 16'h5000, 32'h0, 4'hF);
        tick();
        idle();
        chk("um_fault", bus.o_fault, 1'b1);
        chk("um_sel", bus.o_rgn_sel, 4'b0000);
        chk("um_we", bus.o_rgn_we, 1'b0);
        chk("um_faddr", bus.o_fault_addr, 16'h5000);
        chk("um_fcnt", bus.o_fault_cnt, 8'd1);
        tick();
        chk("um_fault_pulse", bus.o_fault, 1'b0);
        chk("um_ldvld", bus.o_ld_vld, 1'b1);
        chk("um_lddata", bus.o_ld_data, 32'h0);
        req(1'b1, 16'h6000, 32'h12345678, 4'hF);
        tick();
        idle();
        chk("um2_fault", bus.o_fault, 1'b1);
        chk("um2_we", bus.o_rgn_we, 1'b0);
        chk("um2_faddr", bus.o_fault_addr, 16'h5000);
        chk("um2_fcnt", bus.o_fault_cnt, 8'd2);
        tick();
        chk("um2_noldvld", bus.o_ld_vld, 1'b0);

        // Clear coinciding with a fault
        req(1'b1, 16'h5000, 32'h0, 4'hF);
        bus.i_fault_clr = 1'b1;
        tick();
        idle();
        bus.i_fault_clr = 1'b0;
        chk("clrf_fcnt", bus.o_fault_cnt, 8'd1);
        chk("clrf_faddr", bus.o_fault_addr, 16'h5000);

        // Saturation
        req(1'b1, 16'h6000, 32'h0, 4'hF);
        for (int i = 0; i < 300; i++) tick();
        idle();
        chk("sat_fcnt", bus.o_fault_cnt, 8'hFF);
        chk("sat_faddr", bus.o_fault_addr, 16'h5000);

        // Plain clear, then the next fault latches its own address
        bus.i_fault_clr = 1'b1;
        tick();
        bus.i_fault_clr = 1'b0;
        chk("clr_fcnt", bus.o_fault_cnt, 8'd0);
        chk("clr_faddr", bus.o_fault_addr, 16'h0);
        req(1'b1, 16'h6000, 32'h0, 4'hF);
        tick();
        idle();
        chk("new_faddr", bus.o_fault_addr, 16'h6000);
        chk("new_fcnt", bus.o_fault_cnt, 8'd1);
        tick();

        // Reset with a load in flight
        req(1'b0, 16'h7010, 32'h0, 4'hF);
        tick();
        idle();
        chk("rf_sel", bus.o_rgn_sel, 4'b0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rf_ldvld", bus.o_ld_vld, 1'b0);
        chk("rf_sel0", bus.o_rgn_sel, 4'b0000);
        chk("rf_addr0", bus.o_rgn_addr, 16'h0);
        chk("rf_fcnt0", bus.o_fault_cnt, 8'h0);
        chk("rf_faddr0", bus.o_fault_addr, 16'h0);
        chk("rf_lddata0", bus.o_ld_data, 32'h0);
        tick();
        chk("rf_ldvld_after", bus.o_ld_vld, 1'b0);

        // Misaligned word store inside DMEM
        req(1'b1, 16'h2002, 32'hCAFEF00D, 4'hF);
        tick();
        idle();
`ifdef LSU_ROUTER_ALIGN_CHECK_EN
        chk("al_sel", bus.o_rgn_sel, 4'b0000);
        chk("al_fault", bus.o_fault, 1'b1);
        chk("al_we", bus.o_rgn_we, 1'b0);
`else
        chk("al_sel", bus.o_rgn_sel, 4'b0010);
        chk("al_fault", bus.o_fault, 1'b0);
        chk("al_we", bus.o_rgn_we, 1'b1);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_region_router.md
Name: lsu_region_router

Overview:
- Parametrised LSU address router. It is the successor to the fixed two-way LSU write decoder.
- Decodes each LSU access against N_REGION base/mask windows and drives one registered select per region, with shared write data and strobes.
- Returns load data through a tracked read-return pipe and flags unmapped accesses with a sticky fault record.
- Sits between the LSU and the data memory / peripheral register banks.

Parameters:
- ADDR_W, 16, LSU address width.
- DATA_W, 32, data width; must be a multiple of 8.
- N_REGION, 4, number of decoded regions (2..8).
- RGN_BASE, {16'h7000,16'h2000,...}, packed array [N_REGION][ADDR_W], region base addresses.
- RGN_MASK, {16'hFFC0,16'hE000,...}, packed array [N_REGION][ADDR_W]. A bit set means that address bit must equal the base bit.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_lsu_vld  in  1  access request valid.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_addr  in  ADDR_W  byte address.
- i_lsu_wdata  in  DATA_W  store data.
- i_lsu_bmask  in  DATA_W/8  byte enables.
- o_rgn_sel  out  N_REGION  one-hot region select, registered.
- o_rgn_we  out  1  registered write enable.
- o_rgn_addr  out  ADDR_W  registered address.
- o_rgn_wdata  out  DATA_W  registered store data.
- o_rgn_bmask  out  DATA_W/8  registered byte enables.
- i_rgn_rdata  in  N_REGION*DATA_W  per-region read data, valid one cycle after select.
- o_ld_vld  out  1  load data valid pulse.
- o_ld_data  out  DATA_W  load data.
- o_fault  out  1  one-cycle pulse on an unmapped access.
- o_fault_addr  out  ADDR_W  address of the first unmapped access since the last clear.
- o_fault_cnt  out  8  number of faults, saturating.
- i_fault_clr  in  1  clears o_fault_addr, o_fault_cnt and the sticky latch.

Behaviour:
- Reset (i_rst_n low at a rising edge of i_clk): every output goes to 0 and all pipe valids clear. Any in-flight load is dropped; no o_ld_vld is produced for it.
- Region hit: hit[k] = ((i_lsu_addr ^ RGN_BASE[k]) & RGN_MASK[k]) == 0.
- Overlapping regions: the lowest index wins, so o_rgn_sel is always one-hot or zero.
- Stage 1 (cycle T+1 after an accepted request at T):
  - o_rgn_sel holds the winning region, gated by i_lsu_vld.
  - o_rgn_we/addr/wdata/bmask are registered copies of the request.
  - When there is no request, o_rgn_sel = 0 and o_rgn_we = 0. Data outputs hold their last value.
- Stage 2 (cycle T+2, loads only):
  - o_ld_vld = 1.
  - o_ld_data = i_rgn_rdata slice of the region index captured at stage 1.
  - Back-to-back loads give one result per cycle, in order.
- Stores produce no o_ld_vld.
- Unmapped access (valid request, no hit):
  - o_rgn_sel = 0 and o_rgn_we = 0 at T+1.
  - o_fault pulses at T+1.
  - An unmapped load still returns o_ld_vld at T+2 with o_ld_data = 0, so the LSU never hangs.
- Fault record:
  - o_fault_addr latches only on the first fault after reset/clear.
  - o_fault_cnt increments per fault and saturates at 8'hFF.
- i_fault_clr and a fault in the same cycle: the clear wins for the old record, then the new fault is recorded. Result: cnt = 1, addr = the new address.
- No backpressure: regions must accept one access per cycle.

Optional Feature:
- Macro LSU_ROUTER_ALIGN_CHECK_EN.
- Enabled: an access is also a fault (same handling as unmapped) when any of these holds:
  - bmask is a halfword pattern and addr[0] = 1;
  - bmask is all ones and addr[1:0] != 0;
  - bmask is non-contiguous.
- Disabled: alignment is not checked; only address decoding can fault.

Decomposition:
- Package lsu_router_pkg holds:
  - the default region constants (DMEM_BASE 16'h2000 / mask 16'hE000; OUTP_BASE 16'h7000 / mask 16'hFFC0; INP_BASE 16'h7800 / mask 16'hFFC0);
  - a typedef for the region index: logic [$clog2(N_REGION)-1:0];
  - the fault-count width constant.
- One sub-module, lsu_region_match: combinational one-hot lowest-index priority match plus encoded index and hit flag.

Test Plan:
- Store to 16'h2004, wdata 32'hDEADBEEF, bmask 4'hF -> at T+1, o_rgn_sel = 4'b0010, o_rgn_we = 1, o_rgn_wdata = 32'hDEADBEEF; no o_ld_vld.
- Back-to-back loads at 16'h7010, 16'h2000, 16'h7020 with region rdata 32'h11/32'h22 -> o_ld_vld on T+2, T+3, T+4 with data 32'h11, 32'h22, 32'h11, in order.
- Load at unmapped 16'h5000 -> o_fault pulse at T+1, o_ld_vld with 32'h0 at T+2, o_fault_addr = 16'h5000, o_fault_cnt = 1. A second fault at 16'h6000 -> addr stays 16'h5000, cnt = 2.
- Fault at 16'h5000 with i_fault_clr in the same cycle -> cnt = 1, addr = 16'h5000. 300 further faults -> cnt saturates at 8'hFF.
- Load in flight, i_rst_n = 0 at T+1 -> no o_ld_vld at T+2; all outputs are 0 after reset.
- With LSU_ROUTER_ALIGN_CHECK_EN: word store to 16'h2002 -> o_fault, o_rgn_sel = 0. Without the macro: o_rgn_sel = 4'b0010 and no fault.
